perf_counter_sampler: RTL and testbench
=======================================

Name: perf_counter_sampler

Overview:
- Initiator for the performance-counter SRAM-like port: addr, we, wdata and combinational rdata, with write-after-read in the same cycle.
- Periodically, or on demand, sweeps a masked set of hardware counters. Optionally read-and-clears each one atomically.
- Streams {index, value, last} samples through a small FIFO with a valid/ready interface to a trace/debug consumer.
- Shares the counter port with the CSR file; CSR accesses always win.

Parameters:
- XLEN, 64, counter/data width
- NR_CNT, 16, number of sweepable counters
- FIRST_IDX, 3, 5-bit port address of counter 0; FIRST_IDX+NR_CNT <= 32 (elaboration assertion)
- FIFO_DEPTH, 4, sample buffer entries, power of two >= 2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  enables the periodic timer
- period_i  in  32  cycles between sweeps; 0 disables periodic sweeps
- trigger_i  in  1  one-shot sweep request
- mask_i  in  NR_CNT  counters to sample
- clr_on_rd_i  in  1  zero each counter when it is read
- csr_req_i  in  1  CSR file owns the counter port this cycle
- perf_addr_o  out  5  counter port address
- perf_we_o  out  1  counter port write enable
- perf_data_o  out  XLEN  counter port write data (always 0)
- perf_data_i  in  XLEN  counter port read data, same cycle
- sample_valid_o  out  1  FIFO head valid
- sample_ready_i  in  1  consumer accepts the head
- sample_idx_o  out  5  port address of the sampled counter
- sample_data_o  out  XLEN  sampled value
- sample_last_o  out  1  final sample of the sweep
- sample_ts_o  out  XLEN  sweep timestamp (see Optional Feature)
- busy_o  out  1  sweep in progress
- overrun_o  out  1  sticky: sweep request lost
- overrun_clr_i  in  1  clears overrun_o

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state IDLE, timer and FIFO cleared.
  - All outputs 0: perf_we_o=0, perf_addr_o=0, sample_valid_o=0, busy_o=0, overrun_o=0.
  - Reset asserted mid-sweep aborts the sweep; no partial write is issued after the reset edge.
- Timer:
  - Down-counter loaded with period_i when en_i rises or a sweep starts.
  - Decrements while en_i=1 and period_i!=0. Reaching 1 produces a tick and reloads.
  - en_i=0 freezes the timer; re-enable reloads it.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on a tick or trigger_i. Latch mask_i and clr_on_rd_i, set i=0, busy_o=1.
  - SWEEP:
    - If mask[i]=0: advance i with no access, 1 cycle.
    - If mask[i]=1 and csr_req_i=0 and FIFO count<FIFO_DEPTH: drive perf_addr_o=FIRST_IDX+i and capture perf_data_i into the FIFO that cycle.
    - In that same access cycle, perf_we_o=latched clr (read-and-clear, atomic via write-after-read). Then advance i.
    - Otherwise stall: no access, perf_we_o=0.
    - After i=NR_CNT-1 -> DONE.
  - DONE -> IDLE after 1 cycle; busy_o=0 in IDLE.
- perf_addr_o and perf_we_o are combinational from state/i and are 0 when no access occurs.
- sample_last_o is set on the highest-index set bit of the latched mask. A mask of all zeros gives no samples; the sweep still takes NR_CNT+1 cycles.
- Latency:
  - trigger_i at cycle t: first access at t+1 (if not stalled).
  - sample_valid_o at t+2 (registered FIFO output, no fall-through).
- FIFO:
  - Pop on sample_valid_o&&sample_ready_i.
  - A push and a pop in the same cycle keep the count unchanged.
  - Full blocks access (the pop in the current cycle is not considered).
  - Empty: sample_valid_o=0; outputs hold their last value.
- Overrun:
  - A tick arriving while busy_o=1 sets overrun_o and is dropped.
  - trigger_i while busy is ignored and does not set overrun.
  - overrun_clr_i has priority over a same-cycle set.
- Event-counter increments in the same cycle as a clear-on-read are lost; this is accepted behaviour.

Optional Feature:
- PERF_SAMPLE_TIMESTAMP_EN defined:
  - Free-running XLEN cycle counter, reset to 0, wraps modulo 2^XLEN.
  - Its value at sweep start is latched and stored with every FIFO entry; sample_ts_o presents it.
- Undefined: no counter, no FIFO storage for the timestamp, sample_ts_o tied to 0.

Decomposition:
- Package perf_sample_pkg holds:
  - perf_sample_t {idx[4:0], data, last, ts}
  - sampler_state_e {IDLE, SWEEP, DONE}
  - localparam PERF_CNT_ADDR_W=5
- Sub-module perf_sample_fifo: parameterised synchronous FIFO of perf_sample_t, sync active-high reset, push/pop/full/empty/count.

Test Plan:
- mask=16'h0005, trigger, perf_data_i=addr*10, ready=1 -> accesses at addr 3 then 5; samples (3,30,last=0), (5,50,last=1); busy_o low after 17 cycles.
- clr_on_rd=1, mask=16'h0001 -> perf_we_o=1 with perf_addr_o=3 and perf_data_o=0 in the capture cycle; no other writes.
- FIFO_DEPTH=4, mask=16'hFFFF, ready=0 -> exactly 4 accesses, then stall. Raise ready -> remaining 12 issued, 16 samples total in order.
- csr_req_i held high 3 cycles mid-sweep -> no access in those cycles; the sweep resumes at the same index, nothing skipped or duplicated.
- period_i=10, en_i=1, ready=0 with full mask -> second tick arrives during the stalled sweep; overrun_o=1 until overrun_clr_i.
- rst_i asserted mid-sweep -> next cycle busy_o=0, sample_valid_o=0, perf_we_o=0; a fresh trigger restarts at addr 3.

Source files
------------

// File: rtl/perf_sample_pkg.sv
// perf_sample_pkg: shared types and constants for the performance-counter sampler
package perf_sample_pkg;

    localparam int PERF_CNT_ADDR_W = 5;
    localparam int PERF_XLEN       = 64;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sampler_state_e;

    // Full sample record, used when sweep timestamps are stored
    typedef struct packed {
        logic [PERF_CNT_ADDR_W-1:0] idx;
        logic [PERF_XLEN-1:0]       data;
        logic                       last;
        logic [PERF_XLEN-1:0]       ts;
    } perf_sample_t;

    // Reduced record without timestamp storage
    typedef struct packed {
        logic [PERF_CNT_ADDR_W-1:0] idx;
        logic [PERF_XLEN-1:0]       data;
        logic                       last;
    } perf_sample_nots_t;

endpackage

// File: rtl/perf_sample_fifo.sv
// perf_sample_fifo: synchronous FIFO of sample records with registered head and held output when empty
module perf_sample_fifo
    import perf_sample_pkg::*;
#(
    parameter type T     = perf_sample_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    T               held;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && count != '0;
    assign dout    = count != '0 ? mem[rd_ptr] : held;

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the last popped entry shown while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                held   <= mem[rd_ptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler: sweeps masked counters periodically/on demand into a sample FIFO; PERF_SAMPLE_TIMESTAMP_EN adds sweep timestamps
module perf_counter_sampler
    import perf_sample_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NR_CNT     = 16,
    parameter int FIRST_IDX  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [31:0]                period_i,
    input  logic                       trigger_i,
    input  logic [NR_CNT-1:0]          mask_i,
    input  logic                       clr_on_rd_i,
    input  logic                       csr_req_i,
    output logic [PERF_CNT_ADDR_W-1:0] perf_addr_o,
    output logic                       perf_we_o,
    output logic [XLEN-1:0]            perf_data_o,
    input  logic [XLEN-1:0]            perf_data_i,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic [PERF_CNT_ADDR_W-1:0] sample_idx_o,
    output logic [XLEN-1:0]            sample_data_o,
    output logic                       sample_last_o,
    output logic [XLEN-1:0]            sample_ts_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i
);

    localparam int IW = NR_CNT > 1 ? $clog2(NR_CNT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIRST_IDX + NR_CNT > 32) begin : g_addr_chk
        $error("FIRST_IDX + NR_CNT exceeds the 5-bit counter port");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (XLEN > PERF_XLEN) begin : g_xlen_chk
        $error("XLEN wider than the sample record");
    end

`ifdef PERF_SAMPLE_TIMESTAMP_EN
    typedef perf_sample_t entry_t;
`else
    typedef perf_sample_nots_t entry_t;
`endif

    sampler_state_e    state;
    logic [IW-1:0]     idx;
    logic [NR_CNT-1:0] mask_q;
    logic              clr_q;
    logic [31:0]       timer;
    logic              en_q;
    logic              tick;
    logic              start;
    logic              busy;
    logic              access;
    logic              advance;
    logic              full;
    logic [CW-1:0]     count;
    entry_t            push_data;
    entry_t            head;

    assign busy    = state != IDLE;
    assign tick    = en_i && en_q && period_i != '0 && timer <= 32'd1;
    assign start   = state == IDLE && (tick || trigger_i);
    assign access  = state == SWEEP && mask_q[idx] && !csr_req_i && !full;
    assign advance = state == SWEEP && (!mask_q[idx] || access);

    assign perf_addr_o    = access ? PERF_CNT_ADDR_W'(FIRST_IDX + int'(idx)) : '0;
    assign perf_we_o      = access && clr_q;
    assign perf_data_o    = '0;
    assign busy_o         = busy;
    assign sample_valid_o = count != '0;
    assign sample_idx_o   = head.idx;
    assign sample_data_o  = head.data[XLEN-1:0];
    assign sample_last_o  = head.last;

`ifdef PERF_SAMPLE_TIMESTAMP_EN
    logic [PERF_XLEN-1:0] cycles;
    logic [PERF_XLEN-1:0] ts_q;

    assign sample_ts_o = head.ts[XLEN-1:0];

    // Free-running cycle counter and its snapshot at sweep start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycles <= '0;
            ts_q   <= '0;
        end else begin
            cycles <= cycles + 1'b1;
            if (start) ts_q <= cycles;
        end
    end
`else
    assign sample_ts_o = '0;
`endif

    // Sample record for the current access; last means no higher mask bit remains
    always_comb begin
        push_data      = '0;
        push_data.idx  = perf_addr_o;
        push_data.data = PERF_XLEN'(perf_data_i);
        push_data.last = ((mask_q >> idx) >> 1) == '0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
        push_data.ts   = ts_q;
`endif
    end

    // Period timer: reload on enable rise, sweep start or tick; freeze while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q <= en_i;
            if ((en_i && !en_q) || start || tick) timer <= period_i;
            else if (en_i && period_i != '0) timer <= timer - 32'd1;
        end
    end

    // Sweep sequencer: latch request context, walk every index, then one DONE cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            idx    <= '0;
            mask_q <= '0;
            clr_q  <= 1'b0;
        end else if (start) begin
            state  <= SWEEP;
            idx    <= '0;
            mask_q <= mask_i;
            clr_q  <= clr_on_rd_i;
        end else if (state == DONE) begin
            state <= IDLE;
        end else if (advance) begin
            if (idx == IW'(NR_CNT - 1)) state <= DONE;
            else idx <= idx + 1'b1;
        end
    end

    // Sticky overrun for ticks lost during a sweep; clear wins over set
    always_ff @(posedge clk_i) begin
        if (rst_i) overrun_o <= 1'b0;
        else if (overrun_clr_i) overrun_o <= 1'b0;
        else if (tick && busy) overrun_o <= 1'b1;
    end

    perf_sample_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (access),
        .pop   (sample_ready_i),
        .din   (push_data),
        .dout  (head),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_perf_counter_sampler.sv
// tb_perf_counter_sampler: directed scoreboard bench for perf_counter_sampler
module tb_perf_counter_sampler;
    import perf_sample_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, trigger, clr_on_rd, csr_req, ready, overrun_clr;
    logic [31:0] period;
    logic [15:0] mask;
    logic [4:0]  perf_addr, sample_idx;
    logic        perf_we, sample_valid, sample_last, busy, overrun;
    logic [63:0] perf_wdata, perf_rdata, sample_data, sample_ts;

    always #5 clk = ~clk;

    assign perf_rdata = 64'(perf_addr) * 64'd10;

    perf_counter_sampler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .period_i       (period),
        .trigger_i      (trigger),
        .mask_i         (mask),
        .clr_on_rd_i    (clr_on_rd),
        .csr_req_i      (csr_req),
        .perf_addr_o    (perf_addr),
        .perf_we_o      (perf_we),
        .perf_data_o    (perf_wdata),
        .perf_data_i    (perf_rdata),
        .sample_valid_o (sample_valid),
        .sample_ready_i (ready),
        .sample_idx_o   (sample_idx),
        .sample_data_o  (sample_data),
        .sample_last_o  (sample_last),
        .sample_ts_o    (sample_ts),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .overrun_clr_i  (overrun_clr)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic        we;
        logic [63:0] data;
    } acc_t;

    exp_t exp_q[$];
    acc_t log_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Access logger and sample scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (perf_we || perf_addr != 5'd0) log_q.push_back('{perf_addr, perf_we, perf_wdata});
            if (sample_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample: got idx %0d with none expected", sample_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_idx", 64'(sample_idx), 64'(e.idx));
                    chk("sample_data", sample_data, e.data);
                    chk("sample_last", 64'(sample_last), 64'(e.last));
`ifndef PERF_SAMPLE_TIMESTAMP_EN
                    chk("sample_ts", sample_ts, 64'd0);
`endif
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_trigger();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic expect_range(int first, int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{5'(first + k), 64'((first + k) * 10), k == n - 1});
    endtask

    task automatic chk_log_seq(string name, int first, int n);
        chk({name, "_count"}, 64'(log_q.size()), 64'(n));
        if (log_q.size() == n)
            for (int k = 0; k < n; k++) chk({name, "_addr"}, 64'(log_q[k].addr), 64'(first + k));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; trigger = 1'b0; clr_on_rd = 1'b0; csr_req = 1'b0;
        ready = 1'b0; overrun_clr = 1'b0; period = '0; mask = '0;
        step(3);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valid", 64'(sample_valid), 0);
        chk("rst_we", 64'(perf_we), 0);
        chk("rst_addr", 64'(perf_addr), 0);
        chk("rst_overrun", 64'(overrun), 0);
        rst = 1'b0;
        step(2);

        // Sparse mask, latency and sweep length
        mask = 16'h0005; ready = 1'b1; log_q.delete();
        exp_q.push_back('{5'd3, 64'd30, 1'b0});
        exp_q.push_back('{5'd5, 64'd50, 1'b1});
        do_trigger();
        chk("t1_first_addr", 64'(perf_addr), 3);
        chk("t1_first_we", 64'(perf_we), 0);
        step(1);
        chk("t1_valid_lat", 64'(sample_valid), 1);
        chk("t1_head_idx", 64'(sample_idx), 3);
        step(15);
        chk("t1_busy_last", 64'(busy), 1);
        step(1);
        chk("t1_busy_end", 64'(busy), 0);
        step(2);
        chk("t1_log_count", 64'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            chk("t1_log0", 64'(log_q[0].addr), 3);
            chk("t1_log1", 64'(log_q[1].addr), 5);
        end
        chk("t1_drained", 64'(exp_q.size()), 0);

        // Read-and-clear of a single counter
        clr_on_rd = 1'b1; mask = 16'h0001; log_q.delete();
        exp_q.push_back('{5'd3, 64'd30, 1'b1});
        do_trigger();
        chk("t2_we", 64'(perf_we), 1);
        chk("t2_addr", 64'(perf_addr), 3);
        chk("t2_wdata", perf_wdata, 0);
        wait_idle("t2_idle");
        step(2);
        chk("t2_log_count", 64'(log_q.size()), 1);
        if (log_q.size() == 1) chk("t2_log_we", 64'(log_q[0].we), 1);
        clr_on_rd = 1'b0;

        // FIFO backpressure, busy trigger ignored
        mask = 16'hFFFF; ready = 1'b0; log_q.delete();
        expect_range(3, 16);
        do_trigger();
        step(20);
        chk("t3_stall_count", 64'(log_q.size()), 4);
        chk("t3_busy", 64'(busy), 1);
        chk("t3_valid", 64'(sample_valid), 1);
        chk("t3_head", 64'(sample_idx), 3);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        chk("t3_trig_no_overrun", 64'(overrun), 0);
        ready = 1'b1;
        wait_idle("t3_idle");
        step(6);
        chk_log_seq("t3_log", 3, 16);
        chk("t3_drained", 64'(exp_q.size()), 0);

        // CSR ownership stalls in place
        log_q.delete();
        expect_range(3, 16);
        do_trigger();
        step(2);
        csr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_csr_addr", 64'(perf_addr), 0);
            chk("t4_csr_we", 64'(perf_we), 0);
            @(posedge clk);
            #1;
        end
        csr_req = 1'b0;
        @(negedge clk);
        chk("t4_resume_addr", 64'(perf_addr), 5);
        wait_idle("t4_idle");
        step(3);
        chk_log_seq("t4_log", 3, 16);
        chk("t4_drained", 64'(exp_q.size()), 0);

        // Periodic tick lost during a stalled sweep
        ready = 1'b0; log_q.delete();
        expect_range(3, 16);
        chk("t5_overrun_init", 64'(overrun), 0);
        period = 32'd10; en = 1'b1;
        for (int k = 0; k < 60 && !overrun; k++) step(1);
        chk("t5_overrun_set", 64'(overrun), 1);
        en = 1'b0;
        chk("t5_busy", 64'(busy), 1);
        step(5);
        chk("t5_overrun_sticky", 64'(overrun), 1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("t5_overrun_clr", 64'(overrun), 0);
        ready = 1'b1;
        wait_idle("t5_idle");
        step(6);
        chk_log_seq("t5_log", 3, 16);
        chk("t5_drained", 64'(exp_q.size()), 0);

        // Reset mid-sweep, then a fresh sweep
        log_q.delete();
        expect_range(3, 16);
        do_trigger();
        step(2);
        rst = 1'b1;
        step(1);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_valid", 64'(sample_valid), 0);
        chk("t6_we", 64'(perf_we), 0);
        chk("t6_addr", 64'(perf_addr), 0);
        rst = 1'b0;
        exp_q.delete();
        log_q.delete();
        mask = 16'h0001;
        exp_q.push_back('{5'd3, 64'd30, 1'b1});
        step(1);
        do_trigger();
        chk("t6_restart_addr", 64'(perf_addr), 3);
        wait_idle("t6_idle");
        step(3);
        chk("t6_log_count", 64'(log_q.size()), 1);
        chk("t6_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
